// File: rtl/ddr4_phy_pkg.sv
// Shared DDR4 PHY definitions: CA delay sequencer states and IOD lane tap constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr4_phy_pkg;

   // Default tap counter width of the IOD delay lines.
   localparam int CA_TAP_W = 8;

   // Highest legal tap and the static TX delay the IOD restores on LOAD/reset.
   localparam int CA_MAX_TAP     = 255;
   localparam int CA_DEFAULT_TAP = 1;

   // Sequencer states of ddr4_ca_txdly_ctrl.
   typedef enum logic [2:0] {
      CA_IDLE  = 3'd0,
      CA_LOAD  = 3'd1,
      CA_LWAIT = 3'd2,
      CA_STEP  = 3'd3,
      CA_GAP   = 3'd4,
      CA_DONE  = 3'd5
   } ca_dly_state_t;

endpackage

// File: rtl/ddr4_ca_txdly_ctrl.sv
// Steps one CA lane IOD transmit delay line to a requested tap (optional reload first).
// Latency: DONE 1+N*(1+MOVE_GAP) cycles after accept, plus 1+LOAD_WAIT with reload.
// Backpressure: REQ_READY low while busy; requester holds REQ_VALID until accepted.
module ddr4_ca_txdly_ctrl
   import ddr4_phy_pkg::*;
#(
   parameter int TAP_W       = CA_TAP_W,
   parameter int MAX_TAP     = CA_MAX_TAP,
   parameter int DEFAULT_TAP = CA_DEFAULT_TAP,
   parameter int MOVE_GAP    = 4,
   parameter int LOAD_WAIT   = 8
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [TAP_W-1:0] REQ_TAP,
   input  logic             REQ_LOAD,
   output logic             DONE,
   output logic             ERR,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             DELAY_LINE_LOAD,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam int CNT_MAX = (MOVE_GAP > LOAD_WAIT) ? MOVE_GAP : LOAD_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [TAP_W-1:0] MAX_T     = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] DEF_T     = TAP_W'(DEFAULT_TAP);
   localparam logic [TAP_W-1:0] ONE_T     = TAP_W'(1);
   localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(MOVE_GAP);
   localparam logic [CNT_W-1:0] LWAIT_CNT = CNT_W'(LOAD_WAIT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   ca_dly_state_t    state_q;
   logic [TAP_W-1:0] tgt_q;
   logic [TAP_W-1:0] cur_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dir_q;
   logic             err_q;
   logic             done_q;
   logic             move_q;
   logic             load_q;
   logic             rdy_q;

   logic [TAP_W-1:0] req_tgt;
   logic             step_blocked;

   // Clamp the requested tap and detect a step that would leave 0..MAX_TAP.
   always_comb begin
      req_tgt      = (REQ_TAP > MAX_T) ? MAX_T : REQ_TAP;
      step_blocked = dir_q ? (cur_q >= MAX_T) : (cur_q == '0);
   end

   // Sequencer: IOD pulses are registered one cycle after the state that owns them,
   // so DIRECTION (updated on entry to STEP) always leads MOVE by a cycle.
   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state_q <= CA_IDLE;
         tgt_q   <= DEF_T;
         cur_q   <= DEF_T;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         move_q  <= 1'b0;
         load_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         move_q <= 1'b0;
         load_q <= 1'b0;
         case (state_q)
            CA_IDLE: begin
               if (REQ_VALID) begin
                  tgt_q <= req_tgt;
                  err_q <= 1'b0;
                  dir_q <= (req_tgt > cur_q);
                  rdy_q <= 1'b0;
                  if (REQ_LOAD) begin
                     state_q <= CA_LOAD;
                  end else if (req_tgt == cur_q) begin
                     state_q <= CA_DONE;
                  end else begin
                     state_q <= CA_STEP;
                  end
               end
            end
            CA_LOAD: begin
               load_q  <= 1'b1;
               cur_q   <= DEF_T;
               cnt_q   <= LWAIT_CNT;
               state_q <= CA_LWAIT;
            end
            CA_LWAIT: begin
               if (cnt_q <= ONE_C) begin
                  cnt_q   <= '0;
                  dir_q   <= (tgt_q > cur_q);
                  state_q <= (tgt_q == cur_q) ? CA_DONE : CA_STEP;
               end else begin
                  cnt_q <= cnt_q - ONE_C;
               end
            end
            CA_STEP: begin
               if (step_blocked) begin
                  err_q   <= 1'b1;
                  state_q <= CA_DONE;
               end else begin
                  move_q  <= 1'b1;
                  cur_q   <= dir_q ? (cur_q + ONE_T) : (cur_q - ONE_T);
                  cnt_q   <= GAP_CNT;
                  state_q <= CA_GAP;
               end
            end
            CA_GAP: begin
               if (cnt_q <= ONE_C) begin
                  cnt_q <= '0;
                  if (DELAY_LINE_OUT_OF_RANGE) begin
                     // The IOD refused the last move: undo it in the tracked tap.
                     err_q   <= 1'b1;
                     cur_q   <= dir_q ? (cur_q - ONE_T) : (cur_q + ONE_T);
                     state_q <= CA_DONE;
                  end else if (cur_q == tgt_q) begin
                     state_q <= CA_DONE;
                  end else begin
                     state_q <= CA_STEP;
                  end
               end else begin
                  cnt_q <= cnt_q - ONE_C;
               end
            end
            CA_DONE: begin
               done_q  <= 1'b1;
               rdy_q   <= 1'b1;
               state_q <= CA_IDLE;
            end
            default: begin
               rdy_q   <= 1'b1;
               state_q <= CA_IDLE;
            end
         endcase
      end
   end

   // Drive outputs straight from registers.
   always_comb begin
      REQ_READY            = rdy_q;
      DONE                 = done_q;
      ERR                  = err_q;
      CUR_TAP              = cur_q;
      DELAY_LINE_MOVE      = move_q;
      DELAY_LINE_DIRECTION = dir_q;
      DELAY_LINE_LOAD      = load_q;
   end

endmodule

// File: tb/tb_ddr4_ca_txdly_ctrl.sv
// Directed bench for ddr4_ca_txdly_ctrl: step timing, reload, out-of-range, clamp, mid-run reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr4_ca_txdly_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       arst;
   logic       req_valid, req_ready, req_load, done, err, mv, dir, ld, oor;
   logic [7:0] req_tap, cur_tap;

   logic       b_req_valid, b_req_ready, b_req_load, b_done, b_err, b_mv, b_dir, b_ld, b_oor;
   logic [8:0] b_req_tap, b_cur_tap;

   int n_chk = 0;
   int n_err = 0;

   int done_cyc, mv_cnt, ld_cyc, ld_tap, excl_bad, busy_rdy;
   int mv_cyc[8];
   logic first_dir;

   ddr4_ca_txdly_ctrl #(.TAP_W(8), .MAX_TAP(255), .DEFAULT_TAP(1), .MOVE_GAP(4), .LOAD_WAIT(8)) dut_a (
      .FAB_CLK(clk), .ARST(arst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_TAP(req_tap), .REQ_LOAD(req_load),
      .DONE(done), .ERR(err), .CUR_TAP(cur_tap),
      .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(ld),
      .DELAY_LINE_OUT_OF_RANGE(oor)
   );

   ddr4_ca_txdly_ctrl #(.TAP_W(9), .MAX_TAP(255), .DEFAULT_TAP(1), .MOVE_GAP(1), .LOAD_WAIT(1)) dut_b (
      .FAB_CLK(clk), .ARST(arst),
      .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_TAP(b_req_tap), .REQ_LOAD(b_req_load),
      .DONE(b_done), .ERR(b_err), .CUR_TAP(b_cur_tap),
      .DELAY_LINE_MOVE(b_mv), .DELAY_LINE_DIRECTION(b_dir), .DELAY_LINE_LOAD(b_ld),
      .DELAY_LINE_OUT_OF_RANGE(b_oor)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Issue one request on dut_a and record pulse timing (cycle 1 = first cycle after accept edge).
   task automatic run_req(input logic [7:0] tap, input logic load, input int oor_n, input int max_cyc);
      done_cyc  = -1;
      mv_cnt    = 0;
      ld_cyc    = -1;
      ld_tap    = -1;
      busy_rdy  = 0;
      first_dir = 1'bx;
      foreach (mv_cyc[i]) mv_cyc[i] = -1;
      @(negedge clk);
      req_tap   = tap;
      req_load  = load;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk);
         #1;
         if (mv && ld) excl_bad++;
         if (!done && req_ready) busy_rdy++;
         if (mv) begin
            if (mv_cnt < 8) mv_cyc[mv_cnt] = c;
            if (mv_cnt == 0) first_dir = dir;
            mv_cnt++;
            if (mv_cnt == oor_n) oor = 1'b1;
         end
         if (ld) begin
            ld_cyc = c;
            ld_tap = int'(cur_tap);
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      oor = 1'b0;
   endtask

   initial begin
      int dcount;
      arst        = 1'b1;
      req_valid   = 1'b0;
      req_tap     = '0;
      req_load    = 1'b0;
      oor         = 1'b0;
      b_req_valid = 1'b0;
      b_req_tap   = '0;
      b_req_load  = 1'b0;
      b_oor       = 1'b0;
      excl_bad    = 0;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      chk("rst_ready", req_ready, 1);
      chk("rst_cur", cur_tap, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_move", mv, 0);
      chk("rst_load", ld, 0);
      chk("rst_dir", dir, 0);
      @(negedge clk);
      arst = 1'b0;

      // 1 -> 5: four increments
      run_req(8'd5, 1'b0, 0, 60);
      chk("t1_dir", first_dir, 1);
      chk("t1_nmove", mv_cnt, 4);
      chk("t1_mv0", mv_cyc[0], 1);
      chk("t1_mv1", mv_cyc[1], 6);
      chk("t1_mv2", mv_cyc[2], 11);
      chk("t1_mv3", mv_cyc[3], 16);
      chk("t1_done", done_cyc, 21);
      chk("t1_cur", cur_tap, 5);
      chk("t1_err", err, 0);
      chk("t1_busy_rdy", busy_rdy, 0);

      // 5 -> 2: three decrements
      run_req(8'd2, 1'b0, 0, 60);
      chk("t2_dir", first_dir, 0);
      chk("t2_nmove", mv_cnt, 3);
      chk("t2_mv2", mv_cyc[2], 11);
      chk("t2_done", done_cyc, 16);
      chk("t2_cur", cur_tap, 2);

      // 2 -> 0, then a request for 0 from 0 completes without moving
      run_req(8'd0, 1'b0, 0, 60);
      chk("t3_done", done_cyc, 11);
      chk("t3_cur", cur_tap, 0);
      run_req(8'd0, 1'b0, 0, 10);
      chk("t3_zero_done", done_cyc, 1);
      chk("t3_zero_nmove", mv_cnt, 0);
      chk("t3_zero_cur", cur_tap, 0);
      chk("t3_zero_err", err, 0);

      // 0 -> 40, then reload to default and step to 3
      run_req(8'd40, 1'b0, 0, 300);
      chk("t4_cur40", cur_tap, 40);
      run_req(8'd3, 1'b1, 0, 60);
      chk("t4_ld_cyc", ld_cyc, 1);
      chk("t4_ld_tap", ld_tap, 1);
      chk("t4_nmove", mv_cnt, 2);
      chk("t4_mv0", mv_cyc[0], 10);
      chk("t4_mv1", mv_cyc[1], 15);
      chk("t4_dir", first_dir, 1);
      chk("t4_done", done_cyc, 20);
      chk("t4_cur", cur_tap, 3);

      // Out-of-range reported after the 3rd move of 1 -> 10
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      run_req(8'd10, 1'b0, 3, 80);
      chk("t5_nmove", mv_cnt, 3);
      chk("t5_done", done_cyc, 16);
      chk("t5_err", err, 1);
      chk("t5_cur", cur_tap, 3);
      run_req(8'd3, 1'b0, 0, 10);
      chk("t5_clr_done", done_cyc, 1);
      chk("t5_err_clr", err, 0);

      // Reset during the GAP of the 2nd step of 3 -> 6
      @(negedge clk);
      req_tap   = 8'd6;
      req_load  = 1'b0;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      arst = 1'b1;
      #1;
      chk("t6_ready", req_ready, 1);
      chk("t6_cur", cur_tap, 1);
      chk("t6_done", done, 0);
      chk("t6_err", err, 0);
      chk("t6_move", mv, 0);
      chk("t6_dir", dir, 0);
      @(negedge clk);
      arst = 1'b0;
      dcount = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      chk("t6_no_done", dcount, 0);
      run_req(8'd4, 1'b0, 0, 60);
      chk("t6_after_nmove", mv_cnt, 3);
      chk("t6_after_done", done_cyc, 16);
      chk("t6_after_cur", cur_tap, 4);
      chk("move_load_excl", excl_bad, 0);

      // Clamp: 9-bit request of 300 stops at 255
      @(negedge clk);
      b_req_tap   = 9'd300;
      b_req_valid = 1'b1;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      done_cyc = -1;
      mv_cnt   = 0;
      for (int c = 1; c <= 700; c++) begin
         @(posedge clk);
         #1;
         if (b_mv) mv_cnt++;
         if (b_done) begin
            done_cyc = c;
            break;
         end
      end
      chk("t7_done", done_cyc, 509);
      chk("t7_nmove", mv_cnt, 254);
      chk("t7_cur", b_cur_tap, 255);
      chk("t7_err", b_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
